// File: rtl/d_stream_framer.sv
// Frames a free-running, non-backpressurable sample stream into a valid/ready/last stream.
// A 16-entry FIFO absorbs stalls. A drain phase pads the open frame so it reaches full length.
module d_stream_framer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    LEN_WIDTH   = 16,
    parameter int                    FIFO_AWIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = 32'h0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  dengine_reset,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic [31:0]           drop_count,
    output logic [31:0]           frame_count
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    localparam int                     DEPTH    = 1 << FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH:0]   FULL_CNT = {1'b1, {FIFO_AWIDTH{1'b0}}};
    localparam logic [FIFO_AWIDTH-1:0] PTR_ONE  = {{(FIFO_AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [FIFO_AWIDTH-1:0]  wr_ptr_r, rd_ptr_r, head_ptr_s;
    logic [FIFO_AWIDTH:0]    count_r;
    logic [LEN_WIDTH-1:0]    len_r, len_s, cnt_r, cnt_s, len_eff_s;
    logic [DATA_WIDTH-1:0]   o_data_r, o_data_s;
    logic                    o_valid_r, o_valid_s, o_last_r, o_last_s;
    logic                    busy_r, overflow_r;
    logic [31:0]             drop_count_r, frame_count_r;
    logic                    hs_s, pop_s, full_s, frame_done_s, wr_req_s, wr_en_s;
    logic                    drop_s, flush_s, load_s, avail_s;

    assign hs_s         = o_valid_r & o_ready;
    // The displayed word is the FIFO head unless it is padding, and padding only appears once the FIFO is empty.
    assign pop_s        = hs_s & (count_r != {(FIFO_AWIDTH+1){1'b0}});
    assign full_s       = (count_r == FULL_CNT);
    assign frame_done_s = hs_s & o_last_r;
    assign len_eff_s    = (frame_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : frame_len;
    assign wr_en_s      = wr_req_s & (~full_s | pop_s);
    assign drop_s       = wr_req_s & full_s & ~pop_s;
    assign head_ptr_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    assign avail_s      = pop_s ? (count_r > {{FIFO_AWIDTH{1'b0}}, 1'b1})
                                : (count_r != {(FIFO_AWIDTH+1){1'b0}});
    assign load_s       = (state_r != ST_IDLE) & (~o_valid_r | hs_s) & ~flush_s;

    // Next-state, write request, frame length and in-frame counter
    always_comb begin
        state_s  = state_r;
        wr_req_s = 1'b0;
        flush_s  = 1'b0;
        len_s    = len_r;
        if (hs_s) begin
            cnt_s = o_last_r ? {LEN_WIDTH{1'b0}} : (cnt_r + LEN_ONE);
        end else begin
            cnt_s = cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s  = ST_RUN;
                    len_s    = len_eff_s;
                    cnt_s    = {LEN_WIDTH{1'b0}};
                    wr_req_s = s_valid;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_s  = ST_DRAIN;
                end else begin
                    wr_req_s = s_valid;
                end
                if (frame_done_s) begin
                    len_s = len_eff_s;
                end else begin
                    len_s = len_r;
                end
            end
            ST_DRAIN: begin
                // A frame only counts as open once a word of it is presented; otherwise leave at once.
                if (frame_done_s || ((cnt_r == {LEN_WIDTH{1'b0}}) && !o_valid_r)) begin
                    state_s = ST_IDLE;
                    flush_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                flush_s = 1'b1;
            end
        endcase
    end

    // Output stage: next head word, padding, or bubble
    always_comb begin
        o_valid_s = o_valid_r;
        o_data_s  = o_data_r;
        o_last_s  = o_last_r;
        if (flush_s) begin
            o_valid_s = 1'b0;
            o_last_s  = 1'b0;
        end else if (load_s) begin
            if (avail_s) begin
                o_valid_s = 1'b1;
                o_data_s  = mem_r[head_ptr_s];
                o_last_s  = (cnt_s == (len_s - LEN_ONE));
            end else if ((state_r == ST_DRAIN) && (cnt_s != {LEN_WIDTH{1'b0}})) begin
                o_valid_s = 1'b1;
                o_data_s  = PAD_VALUE;
                o_last_s  = (cnt_s == (len_s - LEN_ONE));
            end else begin
                o_valid_s = 1'b0;
                o_last_s  = 1'b0;
            end
        end else begin
            o_valid_s = o_valid_r;
        end
    end

    // FIFO storage array; contents need no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Control state, FIFO pointers, output registers and statistics
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {FIFO_AWIDTH{1'b0}};
            rd_ptr_r      <= {FIFO_AWIDTH{1'b0}};
            count_r       <= {(FIFO_AWIDTH+1){1'b0}};
            len_r         <= LEN_ONE;
            cnt_r         <= {LEN_WIDTH{1'b0}};
            o_data_r      <= {DATA_WIDTH{1'b0}};
            o_valid_r     <= 1'b0;
            o_last_r      <= 1'b0;
            busy_r        <= 1'b0;
            overflow_r    <= 1'b0;
            drop_count_r  <= 32'd0;
            frame_count_r <= 32'd0;
        end else if (dengine_reset) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {FIFO_AWIDTH{1'b0}};
            rd_ptr_r      <= {FIFO_AWIDTH{1'b0}};
            count_r       <= {(FIFO_AWIDTH+1){1'b0}};
            len_r         <= LEN_ONE;
            cnt_r         <= {LEN_WIDTH{1'b0}};
            o_data_r      <= {DATA_WIDTH{1'b0}};
            o_valid_r     <= 1'b0;
            o_last_r      <= 1'b0;
            busy_r        <= 1'b0;
            overflow_r    <= 1'b0;
            drop_count_r  <= 32'd0;
            frame_count_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            o_data_r  <= o_data_s;
            o_valid_r <= o_valid_s;
            o_last_r  <= o_last_s;
            busy_r    <= (state_s != ST_IDLE);
            if (flush_s) begin
                wr_ptr_r <= {FIFO_AWIDTH{1'b0}};
                rd_ptr_r <= {FIFO_AWIDTH{1'b0}};
                count_r  <= {(FIFO_AWIDTH+1){1'b0}};
            end else begin
                wr_ptr_r <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
                rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
                count_r  <= count_r + {{FIFO_AWIDTH{1'b0}}, wr_en_s} - {{FIFO_AWIDTH{1'b0}}, pop_s};
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (drop_s && (drop_count_r != 32'hFFFF_FFFF)) begin
                drop_count_r <= drop_count_r + 32'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
            if (frame_done_s) begin
                frame_count_r <= frame_count_r + 32'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign o_data      = o_data_r;
    assign o_valid     = o_valid_r;
    assign o_last      = o_last_r;
    assign busy        = busy_r;
    assign overflow    = overflow_r;
    assign drop_count  = drop_count_r;
    assign frame_count = frame_count_r;
endmodule

// File: tb/tb_d_stream_framer.sv
// Directed, table-driven bench for d_stream_framer: expected output words per test live in one table.
module tb_d_stream_framer;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        dengine_reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] frame_len = 16'd4;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic [31:0] o_data;
    logic        o_last;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic [31:0] drop_count;
    logic [31:0] frame_count;

    typedef struct {
        int          id;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rec_t;

    vec_t tbl[64];
    int   nv = 0;
    rec_t cap_q[$];
    int   checks = 0;
    int   errors = 0;

    d_stream_framer dut (
        .clk(clk), .srst(srst), .dengine_reset(dengine_reset), .enable(enable),
        .frame_len(frame_len), .s_data(s_data), .s_valid(s_valid),
        .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .o_ready(o_ready),
        .busy(busy), .overflow(overflow), .drop_count(drop_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so a handshake seen at negedge is the one the next edge takes.
    always @(negedge clk) begin
        if (!srst && !dengine_reset && o_valid && o_ready) begin
            cap_q.push_back('{data: o_data, last: o_last});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input int id, input logic [31:0] d, input logic l);
        tbl[nv] = '{id: id, exp_data: d, exp_last: l};
        nv++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stream(input int id);
        int   n = 0;
        rec_t r;
        for (int i = 0; i < nv; i++) begin
            if (tbl[i].id == id) n++;
        end
        chk($sformatf("t%0d_word_count", id), cap_q.size(), n);
        for (int i = 0; i < nv; i++) begin
            if (tbl[i].id == id && cap_q.size() > 0) begin
                r = cap_q.pop_front();
                chk($sformatf("t%0d_data[%0d]", id, i), r.data, tbl[i].exp_data);
                chk($sformatf("t%0d_last[%0d]", id, i), {31'd0, r.last}, {31'd0, tbl[i].exp_last});
            end
        end
        cap_q.delete();
    endtask

    task automatic send(input logic [31:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    initial begin
        // Expected output tables
        for (int i = 1; i <= 12; i++) add(1, i, (i % 4) == 0);
        for (int i = 1; i <= 16; i++) add(2, i, (i % 8) == 0);
        for (int i = 21; i <= 28; i++) add(2, i, i == 28);
        add(4, 32'hA0A0_0001, 1'b0);
        add(4, 32'hB0B0_0002, 1'b0);
        add(4, 32'hC0C0_0003, 1'b0);
        add(4, 32'h0, 1'b0);
        add(4, 32'h0, 1'b0);
        add(4, 32'h0, 1'b1);
        for (int i = 1; i <= 5; i++) add(5, 32'h50 + i, 1'b1);
        for (int i = 1; i <= 3; i++) add(6, 32'h60 + i, i == 3);

        // Reset values
        tick(2);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_last", {31'd0, o_last}, 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_count", drop_count, 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        srst = 1'b0;
        tick(1);

        // Test 1: frame_len 4, 12 samples, full throughput
        frame_len = 16'd4;
        o_ready   = 1'b1;
        enable    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            s_data  = i;
            s_valid = 1'b1;
            tick(1);
            if (i == 1) chk("t1_valid_after_first_write", {31'd0, o_valid}, 32'd0);
            if (i == 2) begin
                chk("t1_valid_latency", {31'd0, o_valid}, 32'd1);
                chk("t1_first_data", o_data, 32'd1);
            end
        end
        s_valid = 1'b0;
        tick(8);
        check_stream(1);
        chk("t1_frame_count", frame_count, 32'd3);
        chk("t1_busy_run", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        tick(3);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);

        // Test 2/3: stall with overflow, then full FIFO with write and pop every cycle
        frame_len = 16'd8;
        o_ready   = 1'b0;
        enable    = 1'b1;
        for (int i = 1; i <= 20; i++) send(i);
        chk("t2_drop_count", drop_count, 32'd4);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_head_valid", {31'd0, o_valid}, 32'd1);
        chk("t2_head_data", o_data, 32'd1);
        o_ready = 1'b1;
        for (int i = 21; i <= 28; i++) begin
            s_data  = i;
            s_valid = 1'b1;
            tick(1);
        end
        s_valid = 1'b0;
        chk("t3_no_new_drops", drop_count, 32'd4);
        tick(30);
        check_stream(2);
        chk("t3_frame_count", frame_count, 32'd6);
        enable = 1'b0;
        tick(3);

        // Test 4: short frame closed with padding; sample on the stop edge is discarded
        frame_len = 16'd6;
        enable    = 1'b1;
        send(32'hA0A0_0001);
        send(32'hB0B0_0002);
        send(32'hC0C0_0003);
        enable  = 1'b0;
        s_data  = 32'hDDDD_0004;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        chk("t4_busy_drain", {31'd0, busy}, 32'd1);
        tick(10);
        check_stream(4);
        chk("t4_busy_after", {31'd0, busy}, 32'd0);
        chk("t4_frame_count", frame_count, 32'd7);

        // Test 5: frame_len 0 behaves as 1
        frame_len = 16'd0;
        enable    = 1'b1;
        for (int i = 1; i <= 5; i++) send(32'h50 + i);
        tick(5);
        check_stream(5);
        chk("t5_frame_count", frame_count, 32'd12);
        enable = 1'b0;
        tick(3);

        // Test 6: async reset mid-frame with a stalled sink, then a fresh frame
        frame_len = 16'd4;
        o_ready   = 1'b0;
        enable    = 1'b1;
        for (int i = 1; i <= 6; i++) send(32'h70 + i);
        #2;
        srst = 1'b1;
        #1;
        chk("t6_async_o_valid", {31'd0, o_valid}, 32'd0);
        chk("t6_async_o_data", o_data, 32'd0);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        chk("t6_async_overflow", {31'd0, overflow}, 32'd0);
        chk("t6_async_drop_count", drop_count, 32'd0);
        chk("t6_async_frame_count", frame_count, 32'd0);
        enable = 1'b0;
        tick(2);
        srst      = 1'b0;
        tick(1);
        cap_q.delete();
        frame_len = 16'd3;
        o_ready   = 1'b1;
        enable    = 1'b1;
        for (int i = 1; i <= 3; i++) send(32'h60 + i);
        tick(5);
        check_stream(6);
        chk("t6_frame_count", frame_count, 32'd1);
        chk("t6_drop_count", drop_count, 32'd0);

        // Synchronous soft reset clears counters and returns to idle
        dengine_reset = 1'b1;
        tick(1);
        chk("soft_rst_frame_count", frame_count, 32'd0);
        chk("soft_rst_busy", {31'd0, busy}, 32'd0);
        dengine_reset = 1'b0;
        enable        = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/d_stream_framer.md
# d_stream_framer

Upstream stage of the d-engine processing stream. Accepts a free-running, non-backpressurable 32-bit sample stream, such as converter or capture data, and buffers it in a small FIFO. It emits a valid/ready/last stream that drives the engine's `t0_data`/`t0_last`/`t0_valid`/`t0_ready` input, with `last` inserted every `frame_len` samples. Overflow drops are counted, and a clean stop pads the open frame to full length so the downstream processor never sees a truncated frame.

## Interface
- `DATA_WIDTH`, 32, sample width.
- `LEN_WIDTH`, 16, width of frame length and in-frame counter.
- `FIFO_AWIDTH`, 4, log2 of FIFO depth (16 entries).
- `PAD_VALUE`, 32'h0, word emitted when padding a frame during drain.
- `clk`  in  1  single clock for all logic.
- `srst`  in  1  reset, asynchronous and active-high.
- `dengine_reset`  in  1  synchronous soft reset; same effect as `srst`, applied on the clock edge.
- `enable`  in  1  level; 1 = capture and frame, 0 = stop after the current frame.
- `frame_len`  in  LEN_WIDTH  samples per frame; sampled at frame start; 0 treated as 1.
- `s_data`  in  DATA_WIDTH  input sample.
- `s_valid`  in  1  input sample strobe; there is no ready signal.
- `o_data`  out  DATA_WIDTH  output sample.
- `o_last`  out  1  marks the final sample of a frame.
- `o_valid`  out  1  output valid.
- `o_ready`  in  1  downstream ready.
- `busy`  out  1  state != IDLE.
- `overflow`  out  1  sticky; set on any dropped sample; cleared only by reset.
- `drop_count`  out  32  dropped-sample count; saturates at 32'hFFFFFFFF.
- `frame_count`  out  32  completed output frames; wraps.

## Operation
- State machine has three states: IDLE, RUN and DRAIN.
- **IDLE:**
  - FIFO writes are disabled; `s_valid` samples are discarded and not counted as drops.
  - On `enable`=1, latch `frame_len` (0 becomes 1), clear the in-frame counter and go to RUN.
- **RUN:**
  - A sample is written when `s_valid`=1.
  - The FIFO pops on each output handshake (`o_valid & o_ready`).
  - On `enable`=0, go to DRAIN.
- **DRAIN:**
  - FIFO writes are disabled.
  - The FIFO continues to pop. Once it is empty, `o_data`=`PAD_VALUE` is presented with `o_valid`=1 until the frame completes.
  - At frame completion, flush any remaining FIFO entries (discarded, not counted as drops) and go to IDLE.
  - If the in-frame counter is 0 on entry, go to IDLE immediately after the flush.
- **In-frame counter:**
  - Increments on each output handshake.
  - `o_last`=1 when counter == latched_len-1.
  - The handshake with `o_last` resets the counter to 0, increments `frame_count`, and re-latches `frame_len` (in RUN only).
- **Full FIFO:**
  - A write is dropped when the FIFO is full and no pop occurs in the same cycle. A drop increments `drop_count` and sets `overflow`.
  - Full with a simultaneous pop: the write is accepted and occupancy is unchanged.
- **Frame alignment:** framing is counted on the output side only, so drops never shorten a frame.
- **Reset (`srst` or `dengine_reset`):**
  - State goes to IDLE; FIFO pointers, occupancy, counters and `overflow` are cleared.
  - Reset mid-frame abandons the frame; no `o_last` is emitted.

## Timing
- Values after reset: `o_valid`=0, `o_last`=0, `o_data`=0, `busy`=0, `overflow`=0, `drop_count`=0, `frame_count`=0.
- Latency: a sample written at edge N appears on `o_data` with `o_valid`=1 after edge N+1. `o_data`, `o_valid` and `o_last` are registered.
- Output handshake rules:
  - Handshake = `o_valid & o_ready` at the clock edge.
  - While `o_valid`=1 and `o_ready`=0, `o_data` and `o_last` are held stable.
  - `o_valid` never deasserts without a handshake, except on reset.
- Throughput: one sample per cycle sustained when `o_ready`=1.
- Transition timing:
  - IDLE→RUN takes effect on the edge where `enable`=1 is seen; a sample present on that same edge is written.
  - RUN→DRAIN: a sample on the edge where `enable`=0 is first seen is discarded.
- `frame_len` changes mid-frame take effect at the next frame start only.
- Drop and frame counters update on the edge after the event.

## Test plan
- `frame_len`=4, `enable`=1, `o_ready`=1, 12 samples 1..12 -> outputs 1..12 with `o_last` on 4, 8 and 12; `frame_count`=3; first `o_valid` one cycle after the first write.
- `frame_len`=8, `o_ready`=0 for 20 cycles while 20 samples (1..20) arrive -> 16 buffered, `drop_count`=4, `overflow`=1; after releasing `o_ready`, samples 1..16 emerge with `o_last` on 8 and 16.
- FIFO full, then `o_ready`=1 with one write per cycle -> no further drops, occupancy stays 16, order preserved.
- `frame_len`=6, 3 samples A,B,C then `enable`=0 -> output A,B,C,`PAD_VALUE`,`PAD_VALUE`,`PAD_VALUE` with `o_last` on the 6th word; then `busy`=0.
- `frame_len`=0 -> every output word has `o_last`=1; `frame_count` increments per word.
- Assert `srst` asynchronously mid-frame with `o_ready`=0 -> all outputs 0 immediately; after release and re-enable, the first frame starts at a counter of 0 and `drop_count`=0.
